// File: rtl/bit_serializer_if.sv
// Handshake/stream bundle for bit_serializer.
//   Load_valid/Load_ready/Din : upstream word load handshake
//   Stall                     : downstream hold request
//   X/X_valid/Last            : serial bit stream to the detector
//   Busy/Word_cnt             : status (word in progress, completed words)
// master = upstream/downstream environment, slave = serializer.
interface bit_serializer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             Load_valid;
   logic             Load_ready;
   logic [WIDTH-1:0] Din;
   logic             Stall;
   logic             X;
   logic             X_valid;
   logic             Last;
   logic             Busy;
   logic [CNT_W-1:0] Word_cnt;

   modport master (
      output Load_valid, Din, Stall,
      input  Load_ready, X, X_valid, Last, Busy, Word_cnt
   );

   modport slave (
      input  Load_valid, Din, Stall,
      output Load_ready, X, X_valid, Last, Busy, Word_cnt
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: WIDTH-bit words in, one bit per Clk out.
//   Clk  : rising-edge clock
//   Clr  : asynchronous active-high clear
//   bus  : slave side of bit_serializer_if (load handshake, Stall,
//          X/X_valid/Last stream, Busy, Word_cnt)
// A word occupies WIDTH unstalled cycles; a new word may be loaded on the
// edge that retires the last bit, so words stream with no gap.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic              Clk,
   input  logic              Clr,
   bit_serializer_if.slave   bus
);
   localparam int             IDX_W    = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH-1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic busy, at_last, x_valid, ready, load, cur_bit;

   assign busy    = (state_q == SHIFT);
   assign at_last = (idx_q == LAST_IDX);
   assign x_valid = busy && !bus.Stall;
   // Ready in IDLE, or on an unstalled last bit so the next word follows gaplessly
   assign ready   = !busy || (at_last && !bus.Stall);
   assign load    = bus.Load_valid && ready;

   // The register physically shifts, so the current bit is always at one end
   assign cur_bit = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

   assign bus.Load_ready = ready;
   assign bus.X_valid    = x_valid;
   assign bus.X          = x_valid & cur_bit;
   assign bus.Last       = x_valid & at_last;
   assign bus.Busy       = busy;
   assign bus.Word_cnt   = cnt_q;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (x_valid) begin
         if (at_last) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = IDLE;
         end else begin
            idx_d  = idx_q + 1'b1;
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
         end
      end
      // A load overrides the retire-to-IDLE of the previous word
      if (load) begin
         state_d = SHIFT;
         sreg_d  = bus.Din;
         idx_d   = '0;
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances share one stimulus stream,
// an MSB-first 16-bit-counter instance and an LSB-first 2-bit-counter one.
// The reference holds each instance's pending word as a queue of bits.
module tb_bit_serializer;
   logic       Clk = 1'b0;
   logic       Clr;
   logic       lv;
   logic [7:0] din;
   logic       st;

   int checks = 0;
   int errors = 0;

   bit          mq[2][$];
   int unsigned mcnt[2];
   int unsigned mmask[2] = '{32'hFFFF, 32'h3};

   bit_serializer_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
   bit_serializer_if #(.WIDTH(8), .CNT_W(2))  bus1 ();

   assign bus0.Load_valid = lv;
   assign bus0.Din        = din;
   assign bus0.Stall      = st;
   assign bus1.Load_valid = lv;
   assign bus1.Din        = din;
   assign bus1.Stall      = st;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_W(16)) u_msb (
      .Clk(Clk), .Clr(Clr), .bus(bus0.slave)
   );
   bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(2)) u_lsb (
      .Clk(Clk), .Clr(Clr), .bus(bus1.slave)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clr();
      for (int d = 0; d < 2; d++) begin
         mq[d].delete();
         mcnt[d] = 0;
      end
   endtask

   task automatic check_outputs();
      logic e_busy[2], e_xv[2], e_x[2], e_last[2], e_rdy[2];
      for (int d = 0; d < 2; d++) begin
         e_busy[d] = mq[d].size() > 0;
         e_xv[d]   = e_busy[d] && !st;
         e_x[d]    = 1'b0;
         if (e_xv[d]) e_x[d] = mq[d][0];
         e_last[d] = e_xv[d] && (mq[d].size() == 1);
         e_rdy[d]  = !e_busy[d] || ((mq[d].size() == 1) && !st);
      end
      chk("msb.X",          32'(bus0.X),          32'(e_x[0]));
      chk("msb.X_valid",    32'(bus0.X_valid),    32'(e_xv[0]));
      chk("msb.Last",       32'(bus0.Last),       32'(e_last[0]));
      chk("msb.Busy",       32'(bus0.Busy),       32'(e_busy[0]));
      chk("msb.Load_ready", 32'(bus0.Load_ready), 32'(e_rdy[0]));
      chk("msb.Word_cnt",   32'(bus0.Word_cnt),   mcnt[0]);
      chk("lsb.X",          32'(bus1.X),          32'(e_x[1]));
      chk("lsb.X_valid",    32'(bus1.X_valid),    32'(e_xv[1]));
      chk("lsb.Last",       32'(bus1.Last),       32'(e_last[1]));
      chk("lsb.Busy",       32'(bus1.Busy),       32'(e_busy[1]));
      chk("lsb.Load_ready", 32'(bus1.Load_ready), 32'(e_rdy[1]));
      chk("lsb.Word_cnt",   32'(bus1.Word_cnt),   mcnt[1]);
   endtask

   // Reference behaviour at a rising edge, from the pre-edge inputs
   task automatic model_edge(input logic l, input logic [7:0] dv, input logic s);
      int  sz;
      bit  xv, rdy, b;
      for (int d = 0; d < 2; d++) begin
         sz  = mq[d].size();
         xv  = (sz > 0) && !s;
         rdy = (sz == 0) || ((sz == 1) && !s);
         if (xv) begin
            b = mq[d].pop_front();
            if (mq[d].size() == 0) mcnt[d] = (mcnt[d] + 1) & mmask[d];
         end
         if (l && rdy) begin
            for (int i = 0; i < 8; i++)
               mq[d].push_back((d == 0) ? dv[7-i] : dv[i]);
         end
      end
   endtask

   // Called at a falling edge; returns at the next falling edge
   task automatic step(input logic l, input logic [7:0] dv, input logic s);
      lv  = l;
      din = dv;
      st  = s;
      #1;
      check_outputs();
      @(posedge Clk);
      model_edge(l, dv, s);
      @(negedge Clk);
   endtask

   initial begin
      Clr = 1'b1;
      lv  = 1'b0;
      din = '0;
      st  = 1'b0;
      model_clr();
      @(negedge Clk);
      #1;
      check_outputs();
      Clr = 1'b0;
      @(negedge Clk);

      // Single word 8'h0D, both bit orders
      step(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("t1.msb_cnt", 32'(bus0.Word_cnt), 32'd1);
      chk("t1.lsb_cnt", 32'(bus1.Word_cnt), 32'd1);

      // Load_valid held: A5 then 0D back to back
      step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
      chk("t3.msb_cnt", 32'(bus0.Word_cnt), 32'd3);

      // Stall mid-word and on the last bit with a pending load
      step(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 8'hA5, 1'b1);
      step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
      chk("t4.msb_cnt", 32'(bus0.Word_cnt), 32'd5);

      // Asynchronous clear while bit 5 is on X
      step(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
      lv = 1'b0;
      st = 1'b0;
      #1;
      check_outputs();
      #1;
      Clr = 1'b1;
      #1;
      model_clr();
      check_outputs();
      chk("t5.xv_after_clr", 32'(bus0.X_valid), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      step(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk("t5.msb_cnt", 32'(bus0.Word_cnt), 32'd1);

      // Five gapless words; 2-bit counter wraps 1,2,3,0,1
      Clr = 1'b1;
      model_clr();
      @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      for (int i = 0; i < 33; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b0);
      chk("t6.msb_cnt", 32'(bus0.Word_cnt), 32'd5);
      chk("t6.lsb_cnt", 32'(bus1.Word_cnt), 32'd1);

      // Random traffic with stalls
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
      for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial feeder that converts WIDTH-bit words into the single-bit stream X consumed by the downstream sequence-detector FSM.
- Upstream side: valid/ready load handshake.
- Downstream side: one bit per Clk, with a qualifier and a stall input.
- Supports gapless back-to-back words and keeps a running count of completed words.

Parameters:
WIDTH, 8, word width in bits (>=2)
LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first
CNT_W, 16, width of the completed-word counter

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  reset, asynchronous, active-high
Load_valid  in  1  upstream word present on Din
Load_ready  out  1  serializer can accept a word this cycle
Din  in  WIDTH  parallel word, sampled on handshake
Stall  in  1  downstream hold; freezes bit position
X  out  1  serial bit to the detector
X_valid  out  1  X carries a real data bit this cycle
Last  out  1  current valid bit is the final bit of the word
Busy  out  1  word in progress
Word_cnt  out  CNT_W  number of fully shifted words, wraps modulo 2^CNT_W

Behaviour:
- Reset and asynchronous reset:
  - Clr clears all state immediately: state=IDLE, shift register=0, bit index=0, Word_cnt=0.
  - Resulting outputs: Busy=0, X_valid=0, X=0, Last=0, Load_ready=1.
- States:
  - IDLE: no word held.
  - SHIFT: word loaded; bit index idx runs 0..WIDTH-1.
- Handshake:
  - A load occurs on a rising edge where Load_valid && Load_ready.
  - Din is captured into the shift register, idx is set to 0, and state goes to SHIFT.
  - Din is ignored at all other times.
- Load_ready (combinational):
  - Equals (state==IDLE) || (state==SHIFT && idx==WIDTH-1 && !Stall).
  - It never depends on Load_valid.
- Output decode (combinational from registered state and Stall):
  - X_valid = (state==SHIFT) && !Stall.
  - X = X_valid ? current bit : 0. The current bit is Din[WIDTH-1-idx] when LSB_FIRST=0, or Din[idx] when LSB_FIRST=1, as captured at load.
  - Last = X_valid && (idx==WIDTH-1).
  - Busy = (state==SHIFT).
- Latency:
  - The first bit appears on X with X_valid=1 in the cycle after the load edge.
  - An unstalled word occupies exactly WIDTH consecutive valid cycles.
- Advance rule: on each edge in SHIFT with !Stall:
  - If idx<WIDTH-1: idx increments.
  - If idx==WIDTH-1: Word_cnt increments, wrapping from 2^CNT_W-1 to 0.
    - With a simultaneous load, the new word is captured, idx=0 and state stays SHIFT. This gives gapless streaming with no idle cycle between words.
    - Otherwise state goes to IDLE.
- Stall:
  - While Stall=1, idx, the shift register and Word_cnt hold.
  - X_valid=0 and X=0, so the downstream FSM sees 0-fill.
  - Load_ready=0 while in SHIFT, including on the last bit.
  - Stall has no effect in IDLE.
- X is always 0 when X_valid=0, including IDLE and stall cycles. X is never X/Z after reset.
- Clr mid-word: the word is discarded, no Last is produced, and Word_cnt returns to 0.

Test Plan:
1. Clr pulse, then load Din=8'h0D (LSB_FIRST=0) -> next 8 cycles X=0,0,0,0,1,1,0,1 with X_valid=1; Last=1 only on the 8th; then Busy=0, Load_ready=1, Word_cnt=1.
2. LSB_FIRST=1, Din=8'h0D -> X=1,0,1,1,0,0,0,0; Word_cnt=1.
3. Load_valid held with 8'hA5 then 8'h0D -> 16 consecutive X_valid cycles with no gap; Load_ready high in the 8th bit cycle; Word_cnt=2 after the 16th bit.
4. Stall=1 for 3 cycles after the 3rd bit of 8'h0D -> X_valid=0 and X=0 for those 3 cycles, then bit 4 (0) resumes. Load_valid asserted during a stall on the last bit is not accepted until Stall drops. Word ends 3 cycles later.
5. Clr asserted asynchronously (mid-cycle) at bit 5 -> immediately X_valid=0, Busy=0, Word_cnt=0; the next load starts cleanly from bit 0.
6. CNT_W=2, five words streamed -> Word_cnt sequence 1,2,3,0,1.
